// File: rtl/hardcopyii_rr_sel4.sv
// Registered round-robin select generator for a 4:1 mux. S/GNT/BUSY are flop outputs held for a whole grant.
// Optional build macro HARDCOPYII_RR_SEL4_LOCK_EN adds lock_i, which suppresses hold-limit expiry.
module hardcopyii_rr_sel4 #(
  parameter int PRIO_RESET = 0,
  parameter int MAX_HOLD   = 8,
  parameter int CNT_W      = 4
) (
  input  logic       clk_i,
  input  logic       sclr_i,
  input  logic       ena_i,
  input  logic [3:0] req_i,
  input  logic       done_i,
`ifdef HARDCOPYII_RR_SEL4_LOCK_EN
  input  logic       lock_i,
`endif
  output logic [1:0] s_o,
  output logic [3:0] gnt_o,
  output logic       busy_o
);

  localparam logic [0:0]       ST_IDLE   = 1'b0;
  localparam logic [0:0]       ST_GRANT  = 1'b1;
  localparam logic [1:0]       PTR_RST   = 2'(PRIO_RESET);
  localparam bit               HOLD_ON   = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  logic [0:0]       state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       s_q, s_d;
  logic [3:0]       gnt_q, gnt_d;

  logic       lock;
  logic       hold_exp;
  logic       grant_end;
  logic [3:0] others;
  logic [1:0] s_inc;
  logic [1:0] pick_first;
  logic [1:0] pick_other;

  // First requester at or after base, wrapping modulo 4.
  function automatic logic [1:0] pick(input logic [3:0] req, input logic [1:0] base);
    logic [1:0] idx;
    pick = base;
    for (int k = 3; k >= 0; k--) begin
      idx = base + 2'(k);
      if (req[idx]) pick = idx;
    end
  endfunction

`ifdef HARDCOPYII_RR_SEL4_LOCK_EN
  assign lock = lock_i;
`else
  assign lock = 1'b0;
`endif

  assign s_inc      = s_q + 2'd1;
  assign others     = req_i & ~(4'b0001 << s_q);
  assign hold_exp   = HOLD_ON && (cnt_q == HOLD_LAST) && !lock;
  assign grant_end  = done_i || !req_i[s_q] || hold_exp;
  assign pick_first = pick(req_i, ptr_q);
  assign pick_other = pick(others, s_inc);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    gnt_d   = gnt_q;
    case (state_q)
      ST_IDLE: begin
        gnt_d = 4'b0000;
        if (req_i != 4'b0000) begin
          state_d = ST_GRANT;
          s_d     = pick_first;
          gnt_d   = 4'b0001 << pick_first;
          cnt_d   = '0;
        end
      end
      default: begin
        if (grant_end) begin
          ptr_d = s_inc;
          // The ending requester is masked so it cannot win the same-edge regrant.
          if (others != 4'b0000) begin
            s_d   = pick_other;
            gnt_d = 4'b0001 << pick_other;
            cnt_d = '0;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = 4'b0000;
          end
        end else if (!lock && cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (sclr_i) begin
      state_q <= ST_IDLE;
      ptr_q   <= PTR_RST;
      cnt_q   <= '0;
      s_q     <= PTR_RST;
      gnt_q   <= 4'b0000;
    end else if (ena_i) begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      gnt_q   <= gnt_d;
    end
  end

  assign s_o    = s_q;
  assign gnt_o  = gnt_q;
  assign busy_o = (state_q == ST_GRANT);

endmodule

// File: tb/tb_hardcopyii_rr_sel4.sv
// Bench for hardcopyii_rr_sel4 (PRIO_RESET=2, MAX_HOLD=8): behavioural model feeds a scoreboard queue,
// plus directed checks of the documented select sequences.
module tb_hardcopyii_rr_sel4;

  localparam int PR = 2;
  localparam int MH = 8;
  localparam int CW = 4;

  logic       clk;
  logic       sclr;
  logic       ena;
  logic [3:0] req;
  logic       done;
`ifdef HARDCOPYII_RR_SEL4_LOCK_EN
  logic       lock;
`endif
  logic [1:0] s_o;
  logic [3:0] gnt_o;
  logic       busy_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0] s;
    logic [3:0] gnt;
    logic       busy;
  } exp_t;
  exp_t sb_q[$];

  // Reference model state
  bit m_busy;
  int m_ptr;
  int m_s;
  int m_cnt;

  hardcopyii_rr_sel4 #(.PRIO_RESET(PR), .MAX_HOLD(MH), .CNT_W(CW)) dut (
    .clk_i  (clk),
    .sclr_i (sclr),
    .ena_i  (ena),
    .req_i  (req),
    .done_i (done),
`ifdef HARDCOPYII_RR_SEL4_LOCK_EN
    .lock_i (lock),
`endif
    .s_o    (s_o),
    .gnt_o  (gnt_o),
    .busy_o (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int first_from(input int p, input logic [3:0] r);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_step();
    bit   lk;
    bit   expire;
    logic [3:0] oth;
    exp_t e;
`ifdef HARDCOPYII_RR_SEL4_LOCK_EN
    lk = lock;
`else
    lk = 1'b0;
`endif
    if (sclr) begin
      m_busy = 0; m_ptr = PR; m_s = PR; m_cnt = 0;
    end else if (ena) begin
      if (!m_busy) begin
        if (req != 4'b0000) begin
          m_s = first_from(m_ptr, req); m_busy = 1; m_cnt = 0;
        end
      end else begin
        expire = (MH != 0) && (m_cnt == MH - 1) && !lk;
        if (done || !req[m_s] || expire) begin
          m_ptr = (m_s + 1) % 4;
          oth = req;
          oth[m_s] = 1'b0;
          if (oth != 4'b0000) begin
            m_s = first_from(m_ptr, oth); m_cnt = 0;
          end else begin
            m_busy = 0;
          end
        end else if (!lk && m_cnt < (1 << CW) - 1) begin
          m_cnt = m_cnt + 1;
        end
      end
    end
    e.s    = 2'(m_s);
    e.gnt  = m_busy ? (4'b0001 << m_s) : 4'b0000;
    e.busy = m_busy;
    sb_q.push_back(e);
  endtask

  // One clock: predict, advance, then pop and compare against the DUT.
  task automatic cycle();
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    checks++;
    if (s_o !== e.s) begin
      errors++; $display("FAIL sb_s t=%0t got=%0d exp=%0d", $time, s_o, e.s);
    end
    checks++;
    if (gnt_o !== e.gnt) begin
      errors++; $display("FAIL sb_gnt t=%0t got=%b exp=%b", $time, gnt_o, e.gnt);
    end
    checks++;
    if (busy_o !== e.busy) begin
      errors++; $display("FAIL sb_busy t=%0t got=%b exp=%b", $time, busy_o, e.busy);
    end
  endtask

  task automatic do_reset();
    sclr = 1'b1; ena = 1'b1; req = 4'b0000; done = 1'b0;
    cycle();
    sclr = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (s_o !== 2'(PR) || gnt_o !== 4'b0000 || busy_o !== 1'b0) begin
      errors++; $display("FAIL reset got s=%0d gnt=%b busy=%b exp s=%0d gnt=0000 busy=0", s_o, gnt_o, busy_o, PR);
    end
  endtask

  task automatic test_first_grant();
    req = 4'b1111;
    cycle();
    checks++;
    if (s_o !== 2'd2 || gnt_o !== 4'b0100 || busy_o !== 1'b1) begin
      errors++; $display("FAIL first_grant got s=%0d gnt=%b busy=%b exp s=2 gnt=0100 busy=1", s_o, gnt_o, busy_o);
    end
  endtask

  task automatic test_back_to_back();
    int exp_seq[4] = '{3, 0, 1, 2};
    done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      checks++;
      if (s_o !== 2'(exp_seq[i]) || busy_o !== 1'b1) begin
        errors++; $display("FAIL back_to_back[%0d] got s=%0d busy=%b exp s=%0d busy=1", i, s_o, busy_o, exp_seq[i]);
      end
    end
    done = 1'b0;
  endtask

  task automatic test_ena_freeze();
    ena = 1'b0; done = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++;
      if (s_o !== 2'd2 || gnt_o !== 4'b0100) begin
        errors++; $display("FAIL ena_freeze[%0d] got s=%0d gnt=%b exp s=2 gnt=0100", i, s_o, gnt_o);
      end
    end
    ena = 1'b1;
    cycle();
    checks++;
    if (s_o !== 2'd3 || gnt_o !== 4'b1000) begin
      errors++; $display("FAIL ena_resume got s=%0d gnt=%b exp s=3 gnt=1000", s_o, gnt_o);
    end
    done = 1'b0;
  endtask

  task automatic test_max_hold();
    int es;
    do_reset();
    req = 4'b0011;
    for (int c = 0; c < 17; c++) begin
      cycle();
      es = (c < 8) ? 0 : (c < 16) ? 1 : 0;
      checks++;
      if (s_o !== 2'(es) || busy_o !== 1'b1) begin
        errors++; $display("FAIL max_hold[%0d] got s=%0d busy=%b exp s=%0d busy=1", c, s_o, busy_o, es);
      end
    end
  endtask

  task automatic test_single_req();
    do_reset();
    req = 4'b0001;
    cycle(); cycle(); cycle();
    done = 1'b1;
    cycle();
    checks++;
    if (gnt_o !== 4'b0000 || busy_o !== 1'b0) begin
      errors++; $display("FAIL single_idle got gnt=%b busy=%b exp gnt=0000 busy=0", gnt_o, busy_o);
    end
    done = 1'b0;
    cycle();
    checks++;
    if (gnt_o !== 4'b0001 || s_o !== 2'd0) begin
      errors++; $display("FAIL single_regrant got gnt=%b s=%0d exp gnt=0001 s=0", gnt_o, s_o);
    end
  endtask

  task automatic test_sclr_mid_grant();
    do_reset();
    req = 4'b1000; done = 1'b1;
    cycle();
    done = 1'b0;
    cycle();
    checks++;
    if (s_o !== 2'd3 || gnt_o !== 4'b1000) begin
      errors++; $display("FAIL sclr_setup got s=%0d gnt=%b exp s=3 gnt=1000", s_o, gnt_o);
    end
    sclr = 1'b1; done = 1'b1;
    cycle();
    sclr = 1'b0; done = 1'b0;
    checks++;
    if (s_o !== 2'(PR) || gnt_o !== 4'b0000 || busy_o !== 1'b0) begin
      errors++; $display("FAIL sclr_abort got s=%0d gnt=%b busy=%b exp s=%0d gnt=0000 busy=0", s_o, gnt_o, busy_o, PR);
    end
    req = 4'b0000;
  endtask

`ifdef HARDCOPYII_RR_SEL4_LOCK_EN
  task automatic test_lock();
    do_reset();
    req = 4'b0011; lock = 1'b1;
    for (int c = 0; c < 12; c++) begin
      cycle();
      checks++;
      if (s_o !== 2'd0 || busy_o !== 1'b1) begin
        errors++; $display("FAIL lock_hold[%0d] got s=%0d busy=%b exp s=0 busy=1", c, s_o, busy_o);
      end
    end
    lock = 1'b0;
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      sclr = ($urandom_range(0, 40) == 0);
      ena  = ($urandom_range(0, 3) != 0);
      req  = 4'($urandom_range(0, 15));
      done = ($urandom_range(0, 3) == 0);
`ifdef HARDCOPYII_RR_SEL4_LOCK_EN
      lock = ($urandom_range(0, 2) == 0);
`endif
      cycle();
    end
    sclr = 1'b0; ena = 1'b1; req = 4'b0000; done = 1'b0;
  endtask

  initial begin
    m_busy = 0; m_ptr = PR; m_s = PR; m_cnt = 0;
    sclr = 1'b1; ena = 1'b1; req = 4'b0000; done = 1'b0;
`ifdef HARDCOPYII_RR_SEL4_LOCK_EN
    lock = 1'b0;
`endif
    test_reset();
    test_first_grant();
    test_back_to_back();
    test_ena_freeze();
    test_max_hold();
    test_single_req();
    test_sclr_mid_grant();
`ifdef HARDCOPYII_RR_SEL4_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
